// File: rtl/note_text_sched.sv
// Round-robin sharing of one registered note-to-ASCII converter between two
// note-text requesters. Optional feature macro: NOTE_TEXT_DEDUP_EN.
module note_text_sched #(
    parameter int                 ADDR_W = 6,
    parameter logic [ADDR_W-1:0]  BASE0  = ADDR_W'(0),
    parameter logic [ADDR_W-1:0]  BASE1  = ADDR_W'(16)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [3:0]        note0,
    output logic              ack0,
    input  logic              req1,
    input  logic [3:0]        note1,
    output logic              ack1,
    output logic [3:0]        conv_hex,
    input  logic [15:0]       conv_ascii,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        CAPT,
        WR_HI,
        WR_LO
    } state_t;

    state_t            state_q;
    logic              last_q;
    logic              gnt_q;
    logic [15:0]       ascii_q;
    logic [3:0]        conv_hex_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              ack0_q;
    logic              ack1_q;

    logic              any_req_d;
    logic              gnt_d;
    logic [3:0]        note_d;
    logic [ADDR_W-1:0] base_g;
    logic              hit_d;

`ifdef NOTE_TEXT_DEDUP_EN
    logic [3:0]        seen0_q;
    logic [3:0]        seen1_q;
    logic [1:0]        vld_q;
    logic              skip_q;
`endif

    // Arbitration: on a tie the requester that did not win last time gets it.
    always_comb begin
        any_req_d = req0 | req1;
        gnt_d     = 1'b0;
        if (req0 && req1) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = req1;
        end
        note_d = gnt_d ? note1 : note0;
        base_g = gnt_q ? BASE1 : BASE0;
        hit_d  = 1'b0;
`ifdef NOTE_TEXT_DEDUP_EN
        if (gnt_d) begin
            hit_d = vld_q[1] && (seen1_q == note_d);
        end else begin
            hit_d = vld_q[0] && (seen0_q == note_d);
        end
`endif
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            ascii_q    <= '0;
            conv_hex_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
`ifdef NOTE_TEXT_DEDUP_EN
            seen0_q    <= '0;
            seen1_q    <= '0;
            vld_q      <= '0;
            skip_q     <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        gnt_q      <= gnt_d;
                        last_q     <= gnt_d;
                        conv_hex_q <= note_d;
                        state_q    <= CONV;
`ifdef NOTE_TEXT_DEDUP_EN
                        skip_q     <= hit_d;
                        if (hit_d) begin
                            ack0_q <= ~gnt_d;
                            ack1_q <= gnt_d;
                        end
`endif
                    end
                end
                CONV: begin
`ifdef NOTE_TEXT_DEDUP_EN
                    state_q <= skip_q ? IDLE : CAPT;
`else
                    state_q <= CAPT;
`endif
                end
                CAPT: begin
                    ascii_q   <= conv_ascii;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= base_g;
                    wr_data_q <= conv_ascii[15:8];
                    state_q   <= WR_HI;
                end
                WR_HI: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= base_g + ADDR_W'(1);
                    wr_data_q <= ascii_q[7:0];
                    ack0_q    <= ~gnt_q;
                    ack1_q    <= gnt_q;
                    state_q   <= WR_LO;
                end
                WR_LO: begin
`ifdef NOTE_TEXT_DEDUP_EN
                    if (gnt_q) begin
                        seen1_q  <= conv_hex_q;
                        vld_q[1] <= 1'b1;
                    end else begin
                        seen0_q  <= conv_hex_q;
                        vld_q[0] <= 1'b1;
                    end
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv_hex = conv_hex_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/note_text_sched.md
# note_text_sched

Controller that shares one registered note-to-ASCII converter between two note-text requesters: the detected-note path (requester 0) and the expected-note path (requester 1). It arbitrates round-robin and sequences the 4-bit note code through the converter. It then writes the resulting two ASCII characters, note letter then `#` or space, into the character display buffer at a per-requester base address. It sits between the note detection/scoring logic and the text display RAM.

## Interface
- `ADDR_W`, 6: display buffer address width.
- `BASE0`, 6'd0: character address of requester 0's text field.
- `BASE1`, 6'd16: character address of requester 1's text field.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req0` in 1: requester 0 wants its note written.
- `note0` in 4: requester 0 note code (0 = rest, 1..12 = C..B).
- `ack0` out 1: one-cycle pulse; requester 0's request is complete.
- `req1`, `note1`, `ack1`: same as above, for requester 1.
- `conv_hex` out 4: note code driven to the converter; registered.
- `conv_ascii` in 16: converter output, `{letter, suffix}`, valid 1 cycle after `conv_hex` is stable.
- `wr_en` out 1: display buffer write strobe.
- `wr_addr` out ADDR_W: display buffer write address.
- `wr_data` out 8: display buffer write character.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, CONV, CAPT, WR_HI, WR_LO.
- IDLE: if any `reqN` is high, grant one requester, latch its note into `conv_hex`, latch the grant index, then go to CONV.
- Arbitration is round-robin on a `last` register. When both requests are high, the requester not equal to `last` wins. When only one request is high, it wins. `last` updates on every grant.
- CONV: wait one cycle for the converter to register `conv_hex`. Then go to CAPT.
- CAPT: latch `conv_ascii` into an internal 16-bit register. Then go to WR_HI.
- WR_HI: `wr_en`=1, `wr_addr`=BASEg, `wr_data`=ascii[15:8]. Then go to WR_LO.
- WR_LO: `wr_en`=1, `wr_addr`=(BASEg+1) mod 2^ADDR_W, `wr_data`=ascii[7:0], `ackg`=1. Then go to IDLE.
- Requesters hold `reqN` and `noteN` stable from assertion until their `ackN`. A request still high in the cycle after `ackN` is treated as a new request.
- Codes 13..15 are passed through unmodified; the converter yields two spaces.
- Only one `ackN` can be high in any cycle. No writes occur except in WR_HI and WR_LO.
- `reset` asserted in any state: next cycle the FSM is in IDLE with all outputs at reset values. No ack is issued for the aborted request, and any partial field write is left as is.

## Timing
- Reset values:
  - `ack0`=`ack1`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `conv_hex`=0, `busy`=0.
  - `last`=1, so requester 0 wins the first tie.
- Request sampled high in IDLE at cycle 0. Then:
  - CONV in cycle 1.
  - CAPT in cycle 2.
  - WR_HI write in cycle 3.
  - WR_LO write plus `ack` in cycle 4.
  - IDLE in cycle 5.
- Throughput: one request per 5 cycles. A pending request is granted in the IDLE cycle 5.
- All outputs are registered or decoded from the state register only. There is no combinational path from `reqN` to any output.

## Configuration
- `NOTE_TEXT_DEDUP_EN` defined:
  - Per-requester 4-bit last-written note register plus a valid bit; valid bits clear on reset.
  - In IDLE, a granted request whose note equals its valid last-written note skips conversion. `ackg` pulses in cycle 1, `wr_en` stays 0, and the FSM returns to IDLE in cycle 2.
  - The last-written note register is updated in WR_LO.
  - Round-robin `last` still updates on a skipped grant.
- `NOTE_TEXT_DEDUP_EN` undefined: every request performs the full 5-cycle sequence. No dedup registers exist.

## Test plan
- Single request: `req0`=1, `note0`=4'd2 (C#). Expected: writes `8'h43` at addr 0 in cycle 3, `8'h23` at addr 1 in cycle 4, `ack0` pulse in cycle 4.
- Simultaneous requests: `req0`=`req1`=1 from reset, `note0`=5, `note1`=12. Expected: requester 0 first (`'E'`,`' '` at 0/1, `ack0` cycle 4). Then requester 1 is granted in cycle 5 (`'B'`,`' '` at 16/17, `ack1` cycle 9).
- Fairness: both requests held continuously for 4 grants. Expected: grants alternate 0,1,0,1; `ack0` and `ack1` are never high together.
- Rest and invalid codes: `note1`=0, then `note1`=4'd14. Expected: both write `8'h20`,`8'h20` at addr 16/17.
- Reset mid-operation: assert `reset` in the WR_HI cycle. Expected: `wr_en`=0 and `busy`=0 the next cycle, no `ack`. A new request then gets the full 5-cycle latency.
- With `NOTE_TEXT_DEDUP_EN`: `note0`=8 written, then `note0`=8 requested again. Expected: `ack0` in cycle 1 with no `wr_en`. A following request with `note0`=9 writes `'G'`,`'#'`.
